// File: rtl/vx_launch_pkg.sv
// vx_launch_pkg: shared definitions for the Vortex launch sequencer.
//   - DCR bus width defaults (overridable from the build)
//   - host command opcode encoding
//   - launch FSM state encoding
//   - max_i helper for sizing the shared timer
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

package vx_launch_pkg;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_DCR_WR = 2'd1;
  localparam logic [1:0] OP_START  = 2'd2;
  localparam logic [1:0] OP_ABORT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DCR,
    ST_RST,
    ST_WAIT_BUSY,
    ST_RUN
  } state_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vx_launch_timer.sv
// vx_launch_timer: loadable down-counter with a zero flag.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, holding at zero
//   zero       : count == 0
module vx_launch_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                    cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vx_launch_ctrl.sv
// vx_launch_ctrl: host-side launch sequencer for the Vortex AXI top.
//   clk, reset      : clock, synchronous active-high reset
//   cmd_valid/ready : host command handshake; cmd_op NOP/DCR_WRITE/START/ABORT
//   cmd_addr/data   : DCR write payload
//   dcr_wr_*        : one-cycle DCR write strobe toward Vortex
//   vx_reset        : Vortex core reset (held high while idle until first START)
//   vx_busy         : Vortex busy
//   running         : launch in progress (RST, WAIT_BUSY, RUN)
//   done / error    : sticky completion / timeout-or-abort flags
//   cycle_count     : cycles spent in RUN for the last or current launch
module vx_launch_ctrl
  import vx_launch_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [`VX_DCR_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [`VX_DCR_DATA_WIDTH-1:0] cmd_data,
  output logic                          dcr_wr_valid,
  output logic [`VX_DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [`VX_DCR_DATA_WIDTH-1:0] dcr_wr_data,
  output logic                          vx_reset,
  input  logic                          vx_busy,
  output logic                          running,
  output logic                          done,
  output logic                          error,
  output logic [CNT_WIDTH-1:0]          cycle_count
);

  localparam int TMR_W = $clog2(max_i(RESET_CYCLES, BUSY_TIMEOUT) + 1);

  state_t             state, state_nx;
  logic               cmd_acc, abort_acc, start_acc, dcr_acc;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  // ABORT bypasses cmd_ready's IDLE-only rule, so it is decoded on its own.
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign abort_acc = cmd_valid && !reset && (cmd_op == OP_ABORT);
  assign start_acc = cmd_acc && (state == ST_IDLE) && (cmd_op == OP_START);
  assign dcr_acc   = cmd_acc && (state == ST_IDLE) && (cmd_op == OP_DCR_WR);

  vx_launch_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_acc) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (start_acc) state_nx = ST_RST;
                      else if (dcr_acc) state_nx = ST_DCR;
        ST_DCR:       state_nx = ST_IDLE;
        ST_RST:       if (tmr_zero) state_nx = ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (vx_busy) state_nx = ST_RUN;
                      else if (tmr_zero) state_nx = ST_IDLE;
        ST_RUN:       if (!vx_busy) state_nx = ST_IDLE;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = !reset && ((state == ST_IDLE) || (cmd_op == OP_ABORT));
    running   = (state == ST_RST) || (state == ST_WAIT_BUSY) || (state == ST_RUN);
    // A write still sitting in DCR is dropped if reset or ABORT lands on it.
    dcr_wr_valid = (state == ST_DCR) && !reset && !abort_acc;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    if (start_acc) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(RESET_CYCLES - 1);
    end else if ((state == ST_RST) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(BUSY_TIMEOUT - 1);
    end else begin
      tmr_dec = (state == ST_RST) || (state == ST_WAIT_BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcr_wr_addr <= '0;
      dcr_wr_data <= '0;
      vx_reset    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      cycle_count <= '0;
    end else begin
      // Every RUN cycle counts, including the one on which the launch ends.
      if (state == ST_RUN) cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (abort_acc) begin
        vx_reset <= 1'b1;
        if (running) error <= 1'b1;
      end else begin
        if (dcr_acc) begin
          dcr_wr_addr <= cmd_addr;
          dcr_wr_data <= cmd_data;
        end
        if (start_acc) begin
          done        <= 1'b0;
          error       <= 1'b0;
          cycle_count <= '0;
          vx_reset    <= 1'b1;
        end
        if ((state == ST_RST) && tmr_zero) vx_reset <= 1'b0;
        if ((state == ST_WAIT_BUSY) && !vx_busy && tmr_zero) begin
          error    <= 1'b1;
          vx_reset <= 1'b1;
        end
        // vx_reset stays low after completion so results remain readable.
        if ((state == ST_RUN) && !vx_busy) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_launch_ctrl.sv
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module tb_vx_launch_ctrl;

  localparam int AW = `VX_DCR_ADDR_WIDTH;
  localparam int DW = `VX_DCR_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          dcr_wr_valid;
  logic [AW-1:0] dcr_wr_addr;
  logic [DW-1:0] dcr_wr_data;
  logic          vx_reset;
  logic          vx_busy;
  logic          running;
  logic          done;
  logic          error;
  logic [63:0]   cycle_count;

  vx_launch_ctrl #(.RESET_CYCLES(16), .BUSY_TIMEOUT(8), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .vx_reset(vx_reset), .vx_busy(vx_busy), .running(running),
    .done(done), .error(error), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } dcr_t;
  typedef struct { logic dn; logic er; logic [63:0] cnt; logic vxr; } end_t;

  dcr_t dcr_q[$];
  end_t end_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_end(input logic dn, input logic er, input logic [63:0] cnt, input logic vxr);
    end_t e;
    e.dn = dn; e.er = er; e.cnt = cnt; e.vxr = vxr;
    end_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dcr_valid"}, 64'(dcr_wr_valid), 64'd0);
    chk({tag, "_dcr_addr"},  64'(dcr_wr_addr),  64'd0);
    chk({tag, "_dcr_data"},  64'(dcr_wr_data),  64'd0);
    chk({tag, "_vx_reset"},  64'(vx_reset),     64'd1);
    chk({tag, "_running"},   64'(running),      64'd0);
    chk({tag, "_done"},      64'(done),         64'd0);
    chk({tag, "_error"},     64'(error),        64'd0);
    chk({tag, "_count"},     cycle_count,       64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready),    64'd0);
  endtask

  // Waits (bounded) for the core reset to be released; returns cycles waited.
  task automatic wait_release(input string tag, output int n);
    n = 0;
    while (vx_reset === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) chk({tag, "_release_timeout"}, 64'(vx_reset), 64'd0);
  endtask

  // Monitor: DCR strobes and end-of-launch (running falling) against the queues.
  logic prev_running = 1'b0;
  always @(negedge clk) begin
    if (dcr_wr_valid === 1'b1) begin
      if (dcr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dcr_unexpected: got addr %0h data %0h expected no write", dcr_wr_addr, dcr_wr_data);
      end else begin
        dcr_t e;
        e = dcr_q.pop_front();
        chk("dcr_addr", 64'(dcr_wr_addr), 64'(e.a));
        chk("dcr_data", 64'(dcr_wr_data), 64'(e.d));
      end
    end
    if (prev_running === 1'b1 && running === 1'b0) begin
      if (end_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL end_unexpected: got launch end expected none");
      end else begin
        end_t e;
        e = end_q.pop_front();
        chk("end_done",     64'(done),     64'(e.dn));
        chk("end_error",    64'(error),    64'(e.er));
        chk("end_count",    cycle_count,   e.cnt);
        chk("end_vx_reset", 64'(vx_reset), 64'(e.vxr));
      end
    end
    prev_running = running;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic ok;
    logic [AW-1:0] ta [3];
    logic [DW-1:0] td [3];
    ta[0] = AW'('h001); td[0] = 32'h8000_0000;
    ta[1] = AW'('h002); td[1] = 32'h0;
    ta[2] = AW'('h003); td[2] = 32'h1234;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0; vx_busy = 1'b0;
    tick(); tick();
    chk_reset_vals("por");
    reset = 1'b0;
    tick();
    chk("idle_ready", 64'(cmd_ready), 64'd1);

    // DCR programming
    for (int i = 0; i < 3; i++) begin
      dcr_t e;
      e.a = ta[i]; e.d = td[i];
      dcr_q.push_back(e);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = ta[i]; cmd_data = td[i];
      tick();
      chk("dcr_ready_low", 64'(cmd_ready), 64'd0);
      chk("dcr_vx_reset", 64'(vx_reset), 64'd1);
      cmd_valid = 1'b0; cmd_op = 2'd0;
      tick();
    end

    // Normal launch
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    push_end(1'b1, 1'b0, 64'd100, 1'b0);
    ok = 1'b1; n = 0;
    while (vx_reset === 1'b1 && n < 40) begin
      if (running !== 1'b1) ok = 1'b0;
      n++;
      tick();
    end
    chk("rst_cycles", 64'(n), 64'd16);
    for (int i = 0; i < 5; i++) begin
      if (running !== 1'b1) ok = 1'b0;
      tick();
    end
    vx_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (running !== 1'b1) ok = 1'b0;
      tick();
    end
    vx_busy = 1'b0;
    chk("running_through", 64'(ok), 64'd1);
    tick();
    chk("ready_after_done", 64'(cmd_ready), 64'd1);
    chk("done_set", 64'(done), 64'd1);
    chk("vx_reset_kept_low", 64'(vx_reset), 64'd0);

    // Busy timeout
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    push_end(1'b0, 1'b1, 64'd0, 1'b1);
    wait_release("tmo", n);
    n = 0;
    while (running === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'd8);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_done", 64'(done), 64'd0);
    chk("tmo_vx_reset", 64'(vx_reset), 64'd1);

    // Abort 20 cycles into RUN
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    wait_release("abt", n);
    vx_busy = 1'b1;
    tick();
    push_end(1'b0, 1'b1, 64'd20, 1'b1);
    for (int i = 0; i < 19; i++) tick();
    cmd_op = 2'd2;
    #1;
    chk("run_ready_low", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_op = 2'd3;
    #1;
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    chk("abort_vx_reset", 64'(vx_reset), 64'd1);
    chk("abort_error", 64'(error), 64'd1);
    tick(); tick();
    vx_busy = 1'b0;
    chk("abort_count_frozen", cycle_count, 64'd20);

    // Busy already high at reset release
    vx_busy = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    push_end(1'b1, 1'b0, 64'd10, 1'b0);
    wait_release("pre", n);
    for (int i = 0; i < 10; i++) tick();
    vx_busy = 1'b0;
    tick();
    chk("pre_done", 64'(done), 64'd1);
    chk("pre_error", 64'(error), 64'd0);

    // Reset during RST
    cmd_valid = 1'b1; cmd_op = 2'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    push_end(1'b0, 1'b0, 64'd0, 1'b1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_in_rst");
    reset = 1'b0;
    tick();

    // Reset during DCR: the pending write never reaches the port
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = AW'('h0AA); cmd_data = 32'h55;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    reset = 1'b1;
    #1;
    chk("dcr_gated_by_reset", 64'(dcr_wr_valid), 64'd0);
    tick();
    chk_reset_vals("rst_in_dcr");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_dcr_after_reset", 64'(dcr_wr_valid), 64'd0);
    end

    tick(); tick();
    chk("dcr_q_drained", 64'(dcr_q.size()), 64'd0);
    chk("end_q_drained", 64'(end_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
